// File: rtl/seq_pkg.sv
// Shared encodings for the microprogram sequencer: opcodes, register control
// codes, FSM states and the decoder's next-state classification.
package seq_pkg;

  localparam int INSTR_W = 8;
  localparam int OP_W    = 3;
  localparam int ARG_W   = INSTR_W - OP_W;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LDX  = 3'b001;
  localparam logic [OP_W-1:0] OP_ALU  = 3'b010;
  localparam logic [OP_W-1:0] OP_MOVZ = 3'b011;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b100;
  localparam logic [OP_W-1:0] OP_REP  = 3'b101;
  localparam logic [OP_W-1:0] OP_JMP  = 3'b110;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  localparam int unsigned REG_HOLD  = 0;
  localparam int unsigned REG_LOAD  = 1;
  localparam int unsigned REG_CLEAR = 2;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, DONE} state_t;

  // What DECODE does with the instruction: run EXEC cycles or handle it inline.
  typedef enum logic [1:0] {CLS_EXEC, CLS_REP, CLS_JMP, CLS_HALT} cls_t;

endpackage

// File: rtl/seq_decoder.sv
// Combinational decode of op/arg into the control values driven during EXEC
// and the class that steers the sequencer out of DECODE.
module seq_decoder
  import seq_pkg::*;
#(
  parameter int DATA_W = 5
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_arg,
  output logic [DATA_W-1:0] o_tx,
  output logic [DATA_W-1:0] o_ty,
  output logic [DATA_W-1:0] o_tz,
  output logic [DATA_W-1:0] o_tula,
  output logic              o_ld_entrada,
  output cls_t              o_cls
);

  always_comb begin
    o_tx         = DATA_W'(REG_HOLD);
    o_ty         = DATA_W'(REG_HOLD);
    o_tz         = DATA_W'(REG_HOLD);
    o_tula       = '0;
    o_ld_entrada = 1'b0;
    o_cls        = CLS_EXEC;
    case (i_op)
      OP_LDX: begin
        o_tx         = DATA_W'(REG_LOAD);
        o_ld_entrada = 1'b1;
      end
      OP_ALU: begin
        o_tula = i_arg;
        o_ty   = DATA_W'(REG_LOAD);
      end
      OP_MOVZ: o_tz = DATA_W'(REG_LOAD);
      OP_CLR: begin
        o_tx = DATA_W'(REG_CLEAR);
        o_ty = DATA_W'(REG_CLEAR);
        o_tz = DATA_W'(REG_CLEAR);
      end
      OP_REP:  o_cls = CLS_REP;
      OP_JMP:  o_cls = CLS_JMP;
      OP_HALT: o_cls = CLS_HALT;
      default: ;
    endcase
  end

endmodule

// File: rtl/sequenciador_controle.sv
// Microprogram sequencer: fetches 8-bit words over req/valid, decodes them and
// drives registered X/Y/Z/ULA control codes for one cycle per execution.
module sequenciador_controle
  import seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               instr_req,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  Tx,
  output logic [DATA_W-1:0]  Ty,
  output logic [DATA_W-1:0]  Tz,
  output logic [DATA_W-1:0]  Tula,
  output logic [DATA_W-1:0]  entrada
);

  state_t              r_state, w_state_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_rep_cnt;
  logic                r_err;
  logic [DATA_W-1:0]   r_tx, r_ty, r_tz, r_tula, r_entrada;

  logic [DATA_W-1:0]   w_arg;
  logic [ADDR_W-1:0]   w_jmp_pc;
  logic [DATA_W-1:0]   w_tx, w_ty, w_tz, w_tula;
  logic                w_ld_entrada;
  cls_t                w_cls;
  logic                w_rep_pend;

  assign w_arg      = DATA_W'(r_ir[ARG_W-1:0]);
  assign w_jmp_pc   = ADDR_W'(w_arg);
  assign w_rep_pend = (r_rep_cnt != '0);

  seq_decoder #(.DATA_W(DATA_W)) u_dec (
    .i_op         (r_ir[INSTR_W-1 -: OP_W]),
    .i_arg        (w_arg),
    .o_tx         (w_tx),
    .o_ty         (w_ty),
    .o_tz         (w_tz),
    .o_tula       (w_tula),
    .o_ld_entrada (w_ld_entrada),
    .o_cls        (w_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start) w_state_nxt = FETCH;
      FETCH:  if (instr_valid) w_state_nxt = DECODE;
      DECODE: begin
        case (w_cls)
          CLS_EXEC: w_state_nxt = EXEC;
          CLS_HALT: w_state_nxt = DONE;
          default:  w_state_nxt = FETCH;
        endcase
      end
      EXEC:   if (!w_rep_pend) w_state_nxt = FETCH;
      DONE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_pc      <= '0;
      r_rep_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_pc      <= '0;
          r_err     <= 1'b0;
          r_rep_cnt <= '0;
        end
        FETCH: if (instr_valid) begin
          r_ir <= instr;
          r_pc <= r_pc + ADDR_W'(1);
        end
        DECODE: if (w_cls != CLS_EXEC) begin
          // Any non-executable op consumes a pending repeat count as an error;
          // REP then installs its own count (zero for JMP/HALT).
          if (w_rep_pend) r_err <= 1'b1;
          r_rep_cnt <= (w_cls == CLS_REP) ? w_arg : '0;
          if (w_cls == CLS_JMP) r_pc <= w_jmp_pc;
        end
        EXEC: if (w_rep_pend) r_rep_cnt <= r_rep_cnt - DATA_W'(1);
        default: ;
      endcase
    end
  end

  // Controls are loaded on the edge entering EXEC so they are valid exactly
  // for the EXEC cycle(s); every other cycle they fall back to HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx      <= DATA_W'(REG_HOLD);
      r_ty      <= DATA_W'(REG_HOLD);
      r_tz      <= DATA_W'(REG_HOLD);
      r_tula    <= '0;
      r_entrada <= '0;
    end else if (w_state_nxt == EXEC) begin
      r_tx   <= w_tx;
      r_ty   <= w_ty;
      r_tz   <= w_tz;
      r_tula <= w_tula;
      if (w_ld_entrada) r_entrada <= w_arg;
    end else begin
      r_tx   <= DATA_W'(REG_HOLD);
      r_ty   <= DATA_W'(REG_HOLD);
      r_tz   <= DATA_W'(REG_HOLD);
      r_tula <= '0;
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign instr_req = (r_state == FETCH);
  assign err       = r_err;
  assign pc        = r_pc;
  assign Tx        = r_tx;
  assign Ty        = r_ty;
  assign Tz        = r_tz;
  assign Tula      = r_tula;
  assign entrada   = r_entrada;

endmodule

// File: tb/tb_sequenciador_controle.sv
// Directed bench for sequenciador_controle: hand-timed programs against a
// small instruction memory with programmable fetch latency.
module tb_sequenciador_controle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start2;
  logic       busy1, done1, err1, req1, valid1;
  logic [7:0] instr1;
  logic [4:0] pc1, tx1, ty1, tz1, tula1, ent1;
  logic       busy2, done2, err2, req2, valid2;
  logic [7:0] instr2;
  logic [1:0] pc2;
  logic [4:0] tx2, ty2, tz2, tula2, ent2;

  logic [7:0] prog1 [32];
  logic [7:0] prog2 [4];
  int errors = 0, checks = 0;
  int delay = 0, wcnt = 0, hs_cnt = 0;

  assign instr1 = prog1[pc1];
  assign valid1 = (delay == 0) ? 1'b1 : (req1 && wcnt == delay);
  assign instr2 = prog2[pc2];
  assign valid2 = 1'b1;

  always @(posedge clk) begin
    if (req1 && !valid1) wcnt <= wcnt + 1;
    else                 wcnt <= 0;
    if (req1 && valid1) hs_cnt <= hs_cnt + 1;
  end

  sequenciador_controle dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .err(err1), .instr_req(req1), .instr_valid(valid1), .instr(instr1),
    .pc(pc1), .Tx(tx1), .Ty(ty1), .Tz(tz1), .Tula(tula1), .entrada(ent1)
  );

  sequenciador_controle #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .err(err2), .instr_req(req2), .instr_valid(valid2), .instr(instr2),
    .pc(pc2), .Tx(tx2), .Ty(ty2), .Tz(tz2), .Tula(tula2), .entrada(ent2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_dut1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic load_basic;
    prog1[0] = 8'h27;  // LDX 7
    prog1[1] = 8'h42;  // ALU 2
    prog1[2] = 8'h60;  // MOVZ
    prog1[3] = 8'hE0;  // HALT
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; delay = 0;
    for (int i = 0; i < 32; i++) prog1[i] = 8'h00;
    for (int i = 0; i < 4; i++) prog2[i] = 8'h00;
    #3;
    checks++;
    if ({busy1, done1, err1, req1} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {busy1, done1, err1, req1});
    end
    checks++;
    if (pc1 !== 5'd0) begin errors++; $display("FAIL reset_pc got %0d exp 0", pc1); end
    checks++;
    if ({tx1, ty1, tz1, tula1, ent1} !== 25'd0) begin
      errors++; $display("FAIL reset_ctrl got %h exp 0", {tx1, ty1, tz1, tula1, ent1});
    end
    checks++;
    if ({busy2, pc2} !== 3'b0) begin errors++; $display("FAIL reset_dut2 got %b exp 000", {busy2, pc2}); end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({busy1, req1} !== 2'b00) begin errors++; $display("FAIL idle_no_start got %b exp 00", {busy1, req1}); end
  endtask

  // LDX 7; ALU 2; MOVZ; HALT with w wait cycles per fetch.
  task automatic test_prog4(input int w);
    int per, tdone, idx;
    logic [20:0] exp_v;
    per = w + 3;
    tdone = 3 * per + w + 2;
    delay = w;
    load_basic();
    start_dut1();
    for (int t = 1; t <= tdone + 1; t++) begin
      tick();
      idx = t / per;
      exp_v = 21'd0;
      if ((t % per) == w + 2 && idx < 3) begin
        case (idx)
          0: exp_v = {5'd1, 5'd0, 5'd0, 5'd0, 1'b0};
          1: exp_v = {5'd0, 5'd1, 5'd0, 5'd2, 1'b0};
          default: exp_v = {5'd0, 5'd0, 5'd1, 5'd0, 1'b0};
        endcase
      end
      if (t == tdone) exp_v[0] = 1'b1;
      checks++;
      if ({tx1, ty1, tz1, tula1, done1} !== exp_v) begin
        errors++;
        $display("FAIL prog4_w%0d_t%0d got %h exp %h", w, t, {tx1, ty1, tz1, tula1, done1}, exp_v);
      end
      if ((t % per) <= w && idx <= 3) begin
        checks++;
        if ({req1, pc1} !== {1'b1, 5'(idx)}) begin
          errors++; $display("FAIL fetch_hold_w%0d_t%0d got req=%b pc=%0d exp req=1 pc=%0d", w, t, req1, pc1, idx);
        end
      end
      if (t == w + 2) begin
        checks++;
        if (ent1 !== 5'd7) begin errors++; $display("FAIL ldx_entrada got %0d exp 7", ent1); end
      end
    end
    checks++;
    if ({busy1, done1, ent1} !== {2'b00, 5'd7}) begin
      errors++; $display("FAIL prog4_end_w%0d got busy=%b done=%b ent=%0d exp 0 0 7", w, busy1, done1, ent1);
    end
    delay = 0;
  endtask

  task automatic test_rep;
    int hs0;
    logic [5:0] exp_v;
    prog1[0] = 8'hA3;  // REP 3
    prog1[1] = 8'h25;  // LDX 5
    prog1[2] = 8'hE0;  // HALT
    hs0 = hs_cnt;
    start_dut1();
    for (int t = 1; t <= 11; t++) begin
      tick();
      exp_v = {(t >= 4 && t <= 7) ? 5'd1 : 5'd0, (t == 10)};
      checks++;
      if ({tx1, done1} !== exp_v) begin
        errors++; $display("FAIL rep_t%0d got %h exp %h", t, {tx1, done1}, exp_v);
      end
      if (t == 7) begin
        checks++;
        if ({ent1, pc1} !== {5'd5, 5'd2}) begin
          errors++; $display("FAIL rep_exec_state got ent=%0d pc=%0d exp 5 2", ent1, pc1);
        end
      end
    end
    checks++;
    if (hs_cnt - hs0 !== 3) begin errors++; $display("FAIL rep_fetches got %0d exp 3", hs_cnt - hs0); end
    checks++;
    if (err1 !== 1'b0) begin errors++; $display("FAIL rep_err got %b exp 0", err1); end
  endtask

  task automatic test_rep_jmp;
    int bad, n;
    prog1[0] = 8'hA2;  // REP 2
    prog1[1] = 8'hC0;  // JMP 0
    start_dut1();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({err1, req1, pc1} !== {2'b11, 5'd0}) begin
      errors++; $display("FAIL jmp_discard got err=%b req=%b pc=%0d exp 1 1 0", err1, req1, pc1);
    end
    checks++;
    if (dut1.r_rep_cnt !== 5'd0) begin errors++; $display("FAIL jmp_repcnt got %0d exp 0", dut1.r_rep_cnt); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if ({tx1, ty1, tz1, tula1} !== 20'd0 || busy1 !== 1'b1 || err1 !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL jmp_loop got %0d bad cycles exp 0", bad); end
    prog1[1] = 8'hE0;  // break the loop: REP 2; HALT
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (done1 !== 1'b1) begin errors++; $display("FAIL halt_timeout got done=%b exp 1", done1); end
    tick();
    checks++;
    if ({busy1, err1} !== 2'b01) begin errors++; $display("FAIL err_sticky got busy=%b err=%b exp 0 1", busy1, err1); end
    prog1[0] = 8'h00;  // NOP; HALT
    start_dut1();
    checks++;
    if ({busy1, err1} !== 2'b10) begin errors++; $display("FAIL err_clear got busy=%b err=%b exp 1 0", busy1, err1); end
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if ({done1, err1} !== 2'b10) begin errors++; $display("FAIL nop_halt got done=%b err=%b exp 1 0", done1, err1); end
    tick();
  endtask

  task automatic test_reset_mid_exec;
    int n, bad;
    load_basic();
    start_dut1();
    n = 0;
    while (ty1 !== 5'd1 && n < 20) begin tick(); n++; end
    checks++;
    if ({ty1, tula1} !== {5'd1, 5'd2}) begin errors++; $display("FAIL alu_exec got ty=%0d tula=%0d exp 1 2", ty1, tula1); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, err1, req1, pc1} !== 9'd0 || {tx1, ty1, tz1, tula1, ent1} !== 25'd0) begin
      errors++; $display("FAIL async_reset got flags=%b pc=%0d ctrl=%h exp 0",
                         {busy1, done1, err1, req1}, pc1, {tx1, ty1, tz1, tula1, ent1});
    end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({busy1, req1} !== 2'b00 || {tx1, ty1, tz1, tula1} !== 20'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL no_resume got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_wrap;
    int bad;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    bad = 0;
    for (int t = 1; t <= 18; t++) begin
      tick();
      start2 = ((t % 3) == 2);
      if (busy2 !== 1'b1) bad++;
      if ((t % 3) == 1) begin
        checks++;
        if (pc2 !== 2'((t / 3) + 1)) begin
          errors++; $display("FAIL wrap_pc_t%0d got %0d exp %0d", t, pc2, ((t / 3) + 1) % 4);
        end
      end
    end
    start2 = 1'b0;
    checks++;
    if (bad !== 0 || done2 !== 1'b0) begin errors++; $display("FAIL wrap_busy got %0d bad cycles done=%b exp 0 0", bad, done2); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_prog4(0);
    test_prog4(3);
    test_rep();
    test_rep_jmp();
    test_reset_mid_exec();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
